// File: rtl/vendo_np.sv
`default_nettype none
// ============================================================================
//  Module   : vendo_np
//  Purpose  : Parametrised coin vending controller. Accepts 1/5/10 peso coins,
//             dispenses one item once credit reaches PRICE, pays any remainder
//             (or the whole credit on cancel) as a train of 1-peso pulses and
//             rejects coins that cannot be accepted.
//  Revision : 1.0  initial release
// ============================================================================
module vendo_np #(
   parameter int PRICE    = 3,
   parameter int CREDIT_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                p1,
   input  logic                p5,
   input  logic                p10,
   input  logic                cancel,
   output logic                disp,
   output logic                change,
   output logic                reject,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit,
   output logic [2:0]          cstate
);

   // The largest credit held before a dispense is PRICE-1+10, so the credit
   // register must be able to hold PRICE+9.
   generate
      if ((PRICE < 1) || (((2 ** CREDIT_W) - 1) < (PRICE + 9))) begin : g_param_check
         $error("vendo_np: PRICE must be >= 1 and 2**CREDIT_W-1 must be >= PRICE+9");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_COLLECT  = 3'd1,
      S_DISPENSE = 3'd2,
      S_CHANGE   = 3'd3,
      S_REFUND   = 3'd4
   } state_t;

   localparam logic [CREDIT_W-1:0] c_price = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] c_one   = CREDIT_W'(1);
   localparam logic [CREDIT_W-1:0] c_five  = CREDIT_W'(5);
   localparam logic [CREDIT_W-1:0] c_ten   = CREDIT_W'(10);

   state_t              r_state;
   state_t              w_state_next;
   logic [CREDIT_W-1:0] r_credit;
   logic [CREDIT_W-1:0] w_credit_next;
   logic                r_phase;
   logic                w_phase_next;
   logic                r_reject;
   logic                w_reject_next;

   logic                r_p1_q;
   logic                r_p5_q;
   logic                r_p10_q;
   logic [2:0]          w_edge;
   logic [1:0]          w_n_edges;
   logic                w_any_edge;
   logic                w_multi_edge;
   logic [CREDIT_W-1:0] w_coin_val;
   logic [CREDIT_W-1:0] w_sum;

   // Coin level history; loaded during reset too so a coin held through
   // reset does not look like a fresh insertion afterwards.
   always_ff @(posedge clk) begin
      r_p1_q  <= p1;
      r_p5_q  <= p5;
      r_p10_q <= p10;
   end

   assign w_edge       = {p10 & ~r_p10_q, p5 & ~r_p5_q, p1 & ~r_p1_q};
   assign w_n_edges    = {1'b0, w_edge[0]} + {1'b0, w_edge[1]} + {1'b0, w_edge[2]};
   assign w_any_edge   = |w_edge;
   assign w_multi_edge = (w_n_edges > 2'd1);
   assign w_sum        = r_credit + w_coin_val;

   // Value of the single inserted coin (only meaningful with exactly one edge).
   always_comb begin
      w_coin_val = '0;
      case (w_edge)
         3'b001:  w_coin_val = c_one;
         3'b010:  w_coin_val = c_five;
         3'b100:  w_coin_val = c_ten;
         default: w_coin_val = '0;
      endcase
   end

   // Next-state, next-credit, phase and reject decisions.
   always_comb begin
      w_state_next  = r_state;
      w_credit_next = r_credit;
      w_phase_next  = r_phase;
      w_reject_next = 1'b0;
      case (r_state)
         S_IDLE, S_COLLECT: begin
            if (cancel && (r_state == S_COLLECT)) begin
               // Refund wins; a coin arriving at the same moment is bounced.
               w_state_next  = S_REFUND;
               w_phase_next  = 1'b0;
               w_reject_next = w_any_edge;
            end else if (w_multi_edge) begin
               w_reject_next = 1'b1;
            end else if (w_any_edge) begin
               w_credit_next = w_sum;
               w_state_next  = (w_sum >= c_price) ? S_DISPENSE : S_COLLECT;
            end
         end
         S_DISPENSE: begin
            w_reject_next = w_any_edge;
            w_credit_next = r_credit - c_price;
            w_phase_next  = 1'b0;
            w_state_next  = (r_credit != c_price) ? S_CHANGE : S_IDLE;
         end
         S_CHANGE, S_REFUND: begin
            // Low cycle (phase 0) then pulse cycle (phase 1) per peso; exit
            // on the low cycle that finds nothing left to pay.
            w_reject_next = w_any_edge;
            w_phase_next  = ~r_phase;
            if (r_phase) begin
               w_credit_next = r_credit - c_one;
            end else if (r_credit == '0) begin
               w_state_next = S_IDLE;
               w_phase_next = 1'b0;
            end
         end
         default: begin
            w_state_next  = S_IDLE;
            w_credit_next = '0;
            w_phase_next  = 1'b0;
         end
      endcase
   end

   // State, credit, phase and reject strobe registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_credit <= '0;
         r_phase  <= 1'b0;
         r_reject <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_credit <= w_credit_next;
         r_phase  <= w_phase_next;
         r_reject <= w_reject_next;
      end
   end

   assign disp   = (r_state == S_DISPENSE);
   assign change = ((r_state == S_CHANGE) || (r_state == S_REFUND)) && r_phase;
   assign busy   = (r_state == S_DISPENSE) || (r_state == S_CHANGE) || (r_state == S_REFUND);
   assign reject = r_reject;
   assign credit = r_credit;
   assign cstate = r_state;

endmodule
`default_nettype wire
